// File: rtl/row_mat_stream_mac.sv
// Streaming 1xK row by KxN weight matrix multiplier: one packed N-lane result
// per input row, NUM_ROWS rows per job, valid/ready on both streams.
//
// state | meaning
// IDLE  | weights writable, waiting for START
// RUN   | accepting row elements, accumulating all N lanes in parallel
// DRAIN | last row consumed, waiting for its result to be accepted
module row_mat_stream_mac #(
    parameter int OP1_COL      = 4,
    parameter int OP1_WIDTH    = 8,
    parameter int WEIGHT_COL   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int DSPOUT_WIDTH = 16,
    parameter int NUM_ROWS     = 8,
    parameter int SATURATE     = 1
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 W_WE,
    input  logic [$clog2(OP1_COL)-1:0]           W_ADDR,
    input  logic [WEIGHT_COL*WEIGHT_WIDTH-1:0]   W_DATA,
    input  logic                                 START,
    input  logic                                 OP1_VALID,
    output logic                                 OP1_READY,
    input  logic [OP1_WIDTH-1:0]                 OP1,
    output logic                                 OUT_VALID,
    input  logic                                 OUT_READY,
    output logic [WEIGHT_COL*DSPOUT_WIDTH-1:0]   OUT,
    output logic                                 OUT_LAST,
    output logic                                 BUSY,
    output logic                                 DONE
);

    localparam int K  = OP1_COL;
    localparam int N  = WEIGHT_COL;
    localparam int KW = $clog2(K);
    localparam int PW = OP1_WIDTH + WEIGHT_WIDTH;
    localparam int AW = PW + KW;
    localparam int DW = DSPOUT_WIDTH;
    localparam int EW = ((AW > DW) ? AW : DW) + 1;
    localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    localparam logic [KW-1:0] K_LAST   = KW'(K - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(NUM_ROWS - 1);

    localparam logic signed [EW-1:0] SAT_MAX = {{(EW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [EW-1:0] SAT_MIN = {{(EW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]                   state_q, state_d;
    logic [KW-1:0]                k_cnt_q, k_cnt_d;
    logic [RW-1:0]                row_cnt_q, row_cnt_d;
    logic signed [AW-1:0]         acc_q [N];
    logic signed [AW-1:0]         acc_d [N];
    logic [N*WEIGHT_WIDTH-1:0]    w_q [K];
    logic [N*WEIGHT_WIDTH-1:0]    w_d [K];
    logic [N*DW-1:0]              out_q, out_d;
    logic                         out_valid_q, out_valid_d;
    logic                         out_last_q, out_last_d;
    logic                         done_q, done_d;

    logic signed [PW-1:0]         prod [N];
    logic signed [AW-1:0]         sum [N];
    logic [N*WEIGHT_WIDTH-1:0]    w_row;
    logic                         k_last;
    logic                         row_last;
    logic                         op1_ready;
    logic                         in_hs;
    logic                         out_hs;

    // Accumulator is wide enough never to overflow; only the lane output narrows.
    function automatic logic [DW-1:0] narrow(input logic signed [AW-1:0] v);
        logic signed [EW-1:0] ve;
        ve = {{(EW-AW){v[AW-1]}}, v};
        if (SATURATE != 0 && ve > SAT_MAX) return SAT_MAX[DW-1:0];
        if (SATURATE != 0 && ve < SAT_MIN) return SAT_MIN[DW-1:0];
        return ve[DW-1:0];
    endfunction

    always_comb begin
        k_last    = (k_cnt_q == K_LAST);
        row_last  = (row_cnt_q == ROW_LAST);
        w_row     = w_q[k_cnt_q];
        // Only the element that would overwrite an unaccepted result is held off.
        op1_ready = (state_q == S_RUN) && !(k_last && out_valid_q && !OUT_READY);
        in_hs     = OP1_VALID && op1_ready;
        out_hs    = out_valid_q && OUT_READY;

        for (int n = 0; n < N; n++) begin
            prod[n] = $signed(OP1) * $signed(w_row[n*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
            sum[n]  = acc_q[n] + {{KW{prod[n][PW-1]}}, prod[n]};
        end

        state_d     = state_q;
        k_cnt_d     = k_cnt_q;
        row_cnt_d   = row_cnt_q;
        acc_d       = acc_q;
        w_d         = w_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        if (out_hs) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (W_WE) begin
                    w_d[W_ADDR] = W_DATA;
                end
                if (START) begin
                    state_d   = S_RUN;
                    k_cnt_d   = '0;
                    row_cnt_d = '0;
                    for (int n = 0; n < N; n++) begin
                        acc_d[n] = '0;
                    end
                end
            end
            S_RUN: begin
                if (in_hs) begin
                    if (k_last) begin
                        for (int n = 0; n < N; n++) begin
                            out_d[n*DW +: DW] = narrow(sum[n]);
                            acc_d[n]          = '0;
                        end
                        out_valid_d = 1'b1;
                        out_last_d  = row_last;
                        k_cnt_d     = '0;
                        if (row_last) begin
                            row_cnt_d = '0;
                            state_d   = S_DRAIN;
                        end else begin
                            row_cnt_d = row_cnt_q + 1'b1;
                        end
                    end else begin
                        acc_d   = sum;
                        k_cnt_d = k_cnt_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (out_hs) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            k_cnt_q     <= '0;
            row_cnt_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            for (int n = 0; n < N; n++) begin
                acc_q[n] <= '0;
            end
            for (int k = 0; k < K; k++) begin
                w_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            k_cnt_q     <= k_cnt_d;
            row_cnt_q   <= row_cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            acc_q       <= acc_d;
            w_q         <= w_d;
        end
    end

    assign OP1_READY = op1_ready;
    assign OUT_VALID = out_valid_q;
    assign OUT       = out_q;
    assign OUT_LAST  = out_last_q;
    assign BUSY      = (state_q != S_IDLE);
    assign DONE      = done_q;

endmodule

// File: tb/tb_row_mat_stream_mac.sv
// Bench for row_mat_stream_mac: single-row vector table on saturating and
// wrapping one-row instances, multi-row job sequences on an 8-row instance.
module tb_row_mat_stream_mac;

    localparam int K  = 4;
    localparam int N  = 8;
    localparam int NR = 8;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         w_we;
    logic [1:0]   w_addr;
    logic [63:0]  w_data;
    logic         start_m, start_1, start_0;
    logic         op1_valid;
    logic [7:0]   op1;
    logic         out_ready;

    logic         op1_ready_m, out_valid_m, out_last_m, busy_m, done_m;
    logic [127:0] out_m;
    logic         op1_ready_1, out_valid_1, out_last_1, busy_1, done_1;
    logic [127:0] out_1;
    logic         op1_ready_0, out_valid_0, out_last_0, busy_0, done_0;
    logic [127:0] out_0;

    row_mat_stream_mac #(.NUM_ROWS(NR), .SATURATE(1)) u_main (
        .CLK(clk), .RST(rst), .W_WE(w_we), .W_ADDR(w_addr), .W_DATA(w_data),
        .START(start_m), .OP1_VALID(op1_valid), .OP1_READY(op1_ready_m), .OP1(op1),
        .OUT_VALID(out_valid_m), .OUT_READY(out_ready), .OUT(out_m),
        .OUT_LAST(out_last_m), .BUSY(busy_m), .DONE(done_m)
    );

    row_mat_stream_mac #(.NUM_ROWS(1), .SATURATE(1)) u_one (
        .CLK(clk), .RST(rst), .W_WE(w_we), .W_ADDR(w_addr), .W_DATA(w_data),
        .START(start_1), .OP1_VALID(op1_valid), .OP1_READY(op1_ready_1), .OP1(op1),
        .OUT_VALID(out_valid_1), .OUT_READY(out_ready), .OUT(out_1),
        .OUT_LAST(out_last_1), .BUSY(busy_1), .DONE(done_1)
    );

    row_mat_stream_mac #(.NUM_ROWS(1), .SATURATE(0)) u_wrap (
        .CLK(clk), .RST(rst), .W_WE(w_we), .W_ADDR(w_addr), .W_DATA(w_data),
        .START(start_0), .OP1_VALID(op1_valid), .OP1_READY(op1_ready_0), .OP1(op1),
        .OUT_VALID(out_valid_0), .OUT_READY(out_ready), .OUT(out_0),
        .OUT_LAST(out_last_0), .BUSY(busy_0), .DONE(done_0)
    );

    typedef struct packed {
        logic [1:0]        wkind;
        logic [3:0][7:0]   xs;
        logic [7:0][15:0]  exp_sat;
        logic [7:0][15:0]  exp_wrap;
    } vec_t;

    vec_t vecs [5];
    int   n_pass  = 0;
    int   n_total = 0;
    int   wm [K][N];

    int           res_cyc [NR];
    logic [127:0] res_val [NR];
    logic         res_last [NR];
    int           n_res, n_in, n_stall, n_bad_stall, n_unstable;
    int           got_done;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // kind 0: W[k][n]=(k+1)*(n+1), 1: all -128, 2: all 127, 3: all 0
    task automatic load_w(input int kind);
        for (int k = 0; k < K; k++) begin
            @(negedge clk);
            w_we   = 1'b1;
            w_addr = 2'(k);
            for (int n = 0; n < N; n++) begin
                case (kind)
                    0: wm[k][n] = (k + 1) * (n + 1);
                    1: wm[k][n] = -128;
                    2: wm[k][n] = 127;
                    default: wm[k][n] = 0;
                endcase
                w_data[n*8 +: 8] = 8'(wm[k][n]);
            end
        end
        @(negedge clk);
        w_we = 1'b0;
    endtask

    function automatic logic [7:0] x_of(input int idx);
        return 8'(idx * 37 + 5);
    endfunction

    function automatic logic [127:0] model_row(input int r);
        logic [127:0]       res;
        logic signed [7:0]  xv;
        int                 s;
        res = '0;
        for (int n = 0; n < N; n++) begin
            s = 0;
            for (int k = 0; k < K; k++) begin
                xv = x_of(r * K + k);
                s += int'(xv) * wm[k][n];
            end
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
            res[n*16 +: 16] = 16'(s);
        end
        return res;
    endfunction

    // Runs one job on the 8-row instance; optional output stall after the first
    // result, a START/W_WE pulse at pulse_cyc, and a reset at abort_cyc.
    task automatic run_main(input int stall_len, input int pulse_cyc, input int abort_cyc);
        int           cyc;
        int           stall_left;
        bit           stall_started;
        bit           hs_in;
        logic [127:0] held;
        n_res = 0; n_in = 0; n_stall = 0; n_bad_stall = 0; n_unstable = 0; got_done = 0;
        cyc = 0; stall_left = 0; stall_started = 1'b0; held = '0;
        @(negedge clk);
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        while (cyc < 300) begin
            if (done_m) begin
                got_done = 1;
                break;
            end
            if (cyc == abort_cyc) begin
                rst       = 1'b1;
                op1_valid = 1'b0;
                @(negedge clk);
                break;
            end
            if (stall_len > 0 && !stall_started && out_valid_m) begin
                stall_started = 1'b1;
                stall_left    = stall_len;
                held          = out_m;
            end
            out_ready = (stall_left == 0);
            op1_valid = (n_in < NR * K);
            op1       = x_of(n_in);
            start_m   = (cyc == pulse_cyc);
            w_we      = (cyc == pulse_cyc);
            w_addr    = 2'd0;
            w_data    = '1;
            #1;
            hs_in = op1_valid && op1_ready_m;
            if (op1_valid && !op1_ready_m) begin
                n_stall++;
                if (n_in != 2 * K - 1) n_bad_stall++;
            end
            if (out_valid_m && !out_ready && out_m !== held) n_unstable++;
            if (out_valid_m && out_ready) begin
                if (n_res < NR) begin
                    res_cyc[n_res]  = cyc;
                    res_val[n_res]  = out_m;
                    res_last[n_res] = out_last_m;
                end
                n_res++;
            end
            @(negedge clk);
            if (hs_in) n_in++;
            if (stall_left > 0) stall_left--;
            cyc++;
        end
        op1_valid = 1'b0;
        start_m   = 1'b0;
        w_we      = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_results(input string tag);
        check_i({tag, "_done"}, got_done, 1);
        check_i({tag, "_n_res"}, n_res, NR);
        for (int i = 0; i < NR; i++) begin
            check($sformatf("%s_row%0d", tag, i), res_val[i], model_row(i));
            check_i($sformatf("%s_last%0d", tag, i), int'(res_last[i]), (i == NR - 1) ? 1 : 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0].wkind = 2'd0; vecs[0].xs = {8'd2, 8'd7, 8'd3, 8'd9};
        vecs[1].wkind = 2'd1; vecs[1].xs = {4{8'h80}};
        vecs[1].exp_sat = {8{16'h7FFF}}; vecs[1].exp_wrap = '0;
        vecs[2].wkind = 2'd2; vecs[2].xs = {4{8'h80}};
        vecs[2].exp_sat = {8{16'h8000}}; vecs[2].exp_wrap = {8{16'd512}};
        vecs[3].wkind = 2'd0; vecs[3].xs = {4{8'hFF}};
        vecs[4].wkind = 2'd2; vecs[4].xs = {4{8'h7F}};
        vecs[4].exp_sat = {8{16'h7FFF}}; vecs[4].exp_wrap = {8{16'hFC04}};
        for (int n = 0; n < N; n++) begin
            vecs[0].exp_sat[n]  = 16'(44 * (n + 1));
            vecs[0].exp_wrap[n] = 16'(44 * (n + 1));
            vecs[3].exp_sat[n]  = 16'(-10 * (n + 1));
            vecs[3].exp_wrap[n] = 16'(-10 * (n + 1));
        end

        rst = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0;
        start_m = 1'b0; start_1 = 1'b0; start_0 = 1'b0;
        op1_valid = 1'b0; op1 = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_i("rst_out_valid", int'(out_valid_m), 0);
        check_i("rst_busy", int'(busy_m), 0);
        check_i("rst_op1_ready", int'(op1_ready_m), 0);
        check_i("rst_done", int'(done_m), 0);
        check("rst_out", out_m, '0);
        rst = 1'b0;

        // single-row vectors on the saturating and wrapping instances
        for (int v = 0; v < 5; v++) begin
            load_w(int'(vecs[v].wkind));
            @(negedge clk);
            start_1 = 1'b1; start_0 = 1'b1;
            @(negedge clk);
            start_1 = 1'b0; start_0 = 1'b0;
            check_i($sformatf("v%0d_busy", v), int'(busy_1), 1);
            for (int k = 0; k < K; k++) begin
                op1_valid = 1'b1;
                op1       = vecs[v].xs[k];
                @(negedge clk);
            end
            op1_valid = 1'b0;
            check_i($sformatf("v%0d_valid", v), int'(out_valid_1), 1);
            check($sformatf("v%0d_sat", v), out_1, vecs[v].exp_sat);
            check($sformatf("v%0d_wrap", v), out_0, vecs[v].exp_wrap);
            check_i($sformatf("v%0d_last", v), int'(out_last_1), 1);
            check_i($sformatf("v%0d_drain_ready", v), int'(op1_ready_1), 0);
            @(negedge clk);
            check_i($sformatf("v%0d_done", v), int'(done_1), 1);
            check_i($sformatf("v%0d_valid_clr", v), int'(out_valid_1), 0);
            check_i($sformatf("v%0d_idle", v), int'(busy_1), 0);
            @(negedge clk);
            check_i($sformatf("v%0d_done_pulse", v), int'(done_1), 0);
        end

        // eight back-to-back rows, no backpressure
        load_w(0);
        run_main(0, -1, -1);
        check_results("t3");
        check_i("t3_n_in", n_in, NR * K);
        check_i("t3_n_stall", n_stall, 0);
        for (int i = 1; i < NR; i++)
            check_i($sformatf("t3_spacing%0d", i), res_cyc[i] - res_cyc[i-1], K);

        // first result held for 10 cycles: only element k=3 of row 1 stalls
        run_main(10, -1, -1);
        check_results("t4");
        check_i("t4_n_in", n_in, NR * K);
        check_i("t4_n_stall", n_stall, 7);
        check_i("t4_bad_stall", n_bad_stall, 0);
        check_i("t4_unstable", n_unstable, 0);

        // START and W_WE mid-job are ignored; a second job confirms weights
        run_main(0, 10, -1);
        check_results("t5a");
        run_main(0, -1, -1);
        check_results("t5b");

        // reset in the middle of row 2
        run_main(0, -1, 9);
        check_i("t6_valid", int'(out_valid_m), 0);
        check_i("t6_busy", int'(busy_m), 0);
        check_i("t6_ready", int'(op1_ready_m), 0);
        check("t6_out", out_m, '0);
        rst = 1'b0;
        for (int k = 0; k < K; k++)
            for (int n = 0; n < N; n++)
                wm[k][n] = 0;
        run_main(0, -1, -1);
        check_results("t6_zero_w");
        load_w(0);
        run_main(0, -1, -1);
        check_results("t6_fresh");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
